// File: rtl/pc_return_stack.sv
// Return-address LIFO for the RAT CPU program counter.
// CALL pushes the return address, RET pops it; the top entry is held in a register.
module pc_return_stack #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [ADDR_W-1:0]          push_addr_i,
    input  logic                       clr_err_i,
    output logic [ADDR_W-1:0]          from_stack_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] top_q, top_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic              isEmpty, isFull;
    logic              wrEn;
    logic [PTR_W-1:0]  wrIdx;
    logic [PTR_W-1:0]  topIdx, belowIdx;

    assign isEmpty  = (count_q == '0);
    assign isFull   = (count_q == CNT_W'(DEPTH));

    // Index arithmetic wraps within PTR_W bits, so a full stack (low bits 0) still
    // resolves its top entry to DEPTH-1.
    assign topIdx   = count_q[PTR_W-1:0] - PTR_W'(1);
    assign belowIdx = count_q[PTR_W-1:0] - PTR_W'(2);

    always_comb begin
        count_d     = count_q;
        top_d       = top_q;
        overflow_d  = overflow_q & ~clr_err_i;
        underflow_d = underflow_q & ~clr_err_i;
        wrEn        = 1'b0;
        wrIdx       = count_q[PTR_W-1:0];

        unique case ({push_i, pop_i})
            2'b10: begin
                if (isFull) begin
                    overflow_d = 1'b1;
                end else begin
                    wrEn    = 1'b1;
                    wrIdx   = count_q[PTR_W-1:0];
                    count_d = count_q + CNT_W'(1);
                    top_d   = push_addr_i;
                end
            end
            2'b01: begin
                if (isEmpty) begin
                    underflow_d = 1'b1;
                end else begin
                    count_d = count_q - CNT_W'(1);
                    top_d   = (count_q >= CNT_W'(2)) ? mem_q[belowIdx] : '0;
                end
            end
            2'b11: begin
                // Simultaneous CALL/RET replaces the top; on an empty stack it degrades to a push.
                wrEn  = 1'b1;
                top_d = push_addr_i;
                if (isEmpty) begin
                    wrIdx       = '0;
                    count_d     = CNT_W'(1);
                    underflow_d = 1'b1;
                end else begin
                    wrIdx = topIdx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q     <= '0;
            top_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            top_q       <= top_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is never cleared; reset only suppresses the write.
    always_ff @(posedge clk_i) begin
        if (rst_ni && wrEn) begin
            mem_q[wrIdx] <= push_addr_i;
        end
    end

    assign from_stack_o = top_q;
    assign empty_o      = isEmpty;
    assign full_o       = isFull;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign underflow_o  = underflow_q;

endmodule
